// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared types and constants for the DPWM drive and monitor blocks
package dpwm_pkg;
  typedef enum logic [2:0] {IDLE, HI, DT_F, LO, DT_R} mon_state_e;
  localparam int CNT_W_DEF = 11;
  localparam int CLK_HZ = 50_000_000;
endpackage

// File: rtl/dpwm_monitor_sync_edge.sv
// sync_edge: multi-flop synchronizer with history flop giving synced level, rise and fall
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end
  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = lvl_o & ~hist_q;
  assign fall_o = ~lvl_o & hist_q;
endmodule

// File: rtl/dpwm_monitor.sv
// dpwm_monitor: measures period, on-time and both dead times of the gate-drive pair
// and flags overlap/sequence faults and loss of switching.
module dpwm_monitor
  import dpwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             EN,
  input  logic             gate_hi,
  input  logic             gate_lo,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] on_cnt,
  output logic [CNT_W-1:0] dt_fall,
  output logic [CNT_W-1:0] dt_rise,
  output logic             meas_valid,
  output logic             overlap_err,
  output logic             timeout_err
);
  localparam logic [CNT_W-1:0] MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  logic hs, hs_r, hs_f, ls, ls_r, ls_f;
  mon_state_e state_q, state_d;
  logic [CNT_W-1:0] pc_q, pc_d, hw_q, hw_d, fw_q, fw_d, rw_q, rw_d;
  logic [CNT_W-1:0] per_q, on_q, dtf_q, dtr_q;
  logic mv_q, ovl_q, ovl_d, to_q, to_d;
  logic seq_err, ovl_hit, to_hit, latch;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hi (
    .clk(clk), .resetn(resetn), .d_i(gate_hi), .lvl_o(hs), .rise_o(hs_r), .fall_o(hs_f)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lo (
    .clk(clk), .resetn(resetn), .d_i(gate_lo), .lvl_o(ls), .rise_o(ls_r), .fall_o(ls_f)
  );

  always_comb begin
    pc_d = (state_q == IDLE) ? pc_q : sat_inc(pc_q);
    hw_d = (state_q == HI) ? sat_inc(hw_q) : hw_q;
    fw_d = (state_q == DT_F) ? sat_inc(fw_q) : fw_q;
    rw_d = (state_q == DT_R) ? sat_inc(rw_q) : rw_q;
    // hs rise in LO is legal only when it coincides with the ls fall (zero dead time)
    seq_err = EN && hs_r && (state_q == HI || state_q == DT_F || (state_q == LO && !ls_f));
    ovl_hit = (hs && ls) || seq_err;
    to_hit = EN && state_q != IDLE && !ovl_hit && pc_q == MAX;
    latch = 1'b0;
    state_d = state_q;
    if (!EN || ovl_hit || to_hit) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = hs_r ? HI : IDLE;
        HI:   state_d = hs_f ? (ls_r ? LO : DT_F) : HI;
        DT_F: state_d = ls_r ? LO : DT_F;
        LO: begin
          state_d = ls_f ? (hs_r ? HI : DT_R) : LO;
          latch = ls_f && hs_r;
        end
        DT_R: begin
          state_d = hs_r ? HI : DT_R;
          latch = hs_r;
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == HI && state_q != HI) begin
      pc_d = CNT_W'(1);
      hw_d = '0;
      fw_d = '0;
      rw_d = '0;
    end
    ovl_d = ovl_hit | (ovl_q & ~clr_err);
    to_d = to_hit | (to_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q <= '0;
      hw_q <= '0;
      fw_q <= '0;
      rw_q <= '0;
      per_q <= '0;
      on_q <= '0;
      dtf_q <= '0;
      dtr_q <= '0;
      mv_q <= 1'b0;
      ovl_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hw_q <= hw_d;
      fw_q <= fw_d;
      rw_q <= rw_d;
      mv_q <= latch;
      ovl_q <= ovl_d;
      to_q <= to_d;
      if (latch) begin
        per_q <= pc_q;
        on_q <= hw_q;
        dtf_q <= fw_q;
        dtr_q <= (state_q == DT_R) ? sat_inc(rw_q) : '0;
      end
    end
  end

  assign period_cnt  = per_q;
  assign on_cnt      = on_q;
  assign dt_fall     = dtf_q;
  assign dt_rise     = dtr_q;
  assign meas_valid  = mv_q;
  assign overlap_err = ovl_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_dpwm_monitor.sv
// tb_dpwm_monitor: directed gate patterns against a period-level scoreboard of expected measurements
module tb_dpwm_monitor;
  localparam int W = 11;
  logic clk = 1'b0, resetn = 1'b0, EN = 1'b0, gate_hi = 1'b0, gate_lo = 1'b0, clr_err = 1'b0;
  logic [W-1:0] period_cnt, on_cnt, dt_fall, dt_rise;
  logic meas_valid, overlap_err, timeout_err;

  typedef struct {int p; int on; int df; int dr;} meas_t;
  meas_t q[$];
  meas_t prev, last;
  bit prev_valid = 0;
  int n_cmp = 0, n_err = 0, n_mv = 0;

  dpwm_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .EN(EN), .gate_hi(gate_hi), .gate_lo(gate_lo), .clr_err(clr_err),
    .period_cnt(period_cnt), .on_cnt(on_cnt), .dt_fall(dt_fall), .dt_rise(dt_rise),
    .meas_valid(meas_valid), .overlap_err(overlap_err), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // every hs rise completes the previous period if one was fully observed
  task automatic rise_model(input meas_t m);
    if (prev_valid) q.push_back(prev);
    prev = m;
    prev_valid = 1;
  endtask

  task automatic period(input int on, input int df, input int lo, input int dr,
                        input bit ovl = 0, input bit en_drop = 0);
    rise_model('{on + df + lo + dr, on, df, dr});
    gate_hi = 1'b1;
    gate_lo = 1'b0;
    for (int i = 0; i < on; i++) begin
      if (ovl && i == on - 5) gate_lo = 1'b1;
      @(negedge clk);
    end
    gate_hi = 1'b0;
    if (df == 0) gate_lo = 1'b1;
    cyc(df);
    gate_lo = 1'b1;
    for (int i = 0; i < lo; i++) begin
      if (en_drop && i == 20) EN = 1'b0;
      if (en_drop && i == 70) EN = 1'b1;
      @(negedge clk);
    end
    gate_lo = 1'b0;
    cyc(dr);
    if (ovl || en_drop) prev_valid = 0;
  endtask

  task automatic chk_out(input string tag, input int p, input int on, input int df, input int dr);
    chk({tag, "_period"}, int'(period_cnt), p);
    chk({tag, "_on"}, int'(on_cnt), on);
    chk({tag, "_dtf"}, int'(dt_fall), df);
    chk({tag, "_dtr"}, int'(dt_rise), dr);
  endtask

  initial begin
    meas_t e;
    last = '{0, 0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        n_mv++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_meas_valid: got 1, expected 0 at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("meas_period", int'(period_cnt), e.p);
          chk("meas_on", int'(on_cnt), e.on);
          chk("meas_dtf", int'(dt_fall), e.df);
          chk("meas_dtr", int'(dt_rise), e.dr);
          last = e;
        end
      end else begin
        chk("hold_period", int'(period_cnt), last.p);
        chk("hold_on", int'(on_cnt), last.on);
        chk("hold_dtf", int'(dt_fall), last.df);
        chk("hold_dtr", int'(dt_rise), last.dr);
      end
    end
  end

  initial begin
    cyc(3);
    chk_out("rst", 0, 0, 0, 0);
    chk("rst_mv", int'(meas_valid), 0);
    chk("rst_ovl", int'(overlap_err), 0);
    chk("rst_to", int'(timeout_err), 0);
    resetn = 1'b1;
    EN = 1'b1;
    cyc(3);
    repeat (3) period(100, 3, 145, 2);
    period(100, 0, 150, 0);
    chk_out("nominal", 250, 100, 3, 2);
    period(100, 0, 150, 0);
    period(100, 3, 145, 2);
    chk_out("zero_dt", 250, 100, 0, 0);
    chk("mv_count_a", n_mv, 5);
    chk("zero_dt_ovl", int'(overlap_err), 0);
    period(100, 3, 145, 2, 1, 0);
    chk("ovl_set", int'(overlap_err), 1);
    chk("ovl_no_to", int'(timeout_err), 0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
    chk("ovl_clr", int'(overlap_err), 0);
    repeat (2) period(100, 3, 145, 2);
    chk("mv_count_b", n_mv, 7);
    rise_model('{0, 0, 0, 0});
    gate_hi = 1'b1;
    cyc(100);
    gate_hi = 1'b0;
    cyc(1890);
    chk("to_not_yet", int'(timeout_err), 0);
    cyc(210);
    prev_valid = 0;
    chk("to_set", int'(timeout_err), 1);
    chk_out("to_hold", 250, 100, 3, 2);
    chk("mv_count_c", n_mv, 8);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
    chk("to_clr", int'(timeout_err), 0);
    rise_model('{0, 0, 0, 0});
    gate_hi = 1'b1;
    cyc(40);
    resetn = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    chk("async_rst_mv", int'(meas_valid), 0);
    last = '{0, 0, 0, 0};
    prev_valid = 0;
    cyc(60);
    gate_hi = 1'b0;
    cyc(3);
    gate_lo = 1'b1;
    cyc(10);
    resetn = 1'b1;
    cyc(135);
    gate_lo = 1'b0;
    cyc(2);
    period(100, 3, 145, 2);
    chk("rst_first_arm", n_mv, 8);
    period(100, 3, 145, 2);
    chk("mv_count_d", n_mv, 9);
    period(100, 3, 145, 2, 0, 1);
    chk("mv_count_e", n_mv, 10);
    chk_out("en_hold", 250, 100, 3, 2);
    repeat (2) period(100, 3, 145, 2);
    rise_model('{0, 0, 0, 0});
    gate_hi = 1'b1;
    cyc(20);
    chk("mv_count_final", n_mv, 12);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
